bcd_scan_driver: RTL and testbench

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

---
 rtl/display_pkg.sv | 36 +++
 rtl/bin2bcd_dd.sv | 40 ++++
 rtl/bcd_scan_driver.sv | 137 +++++++++++++
 tb/tb_bcd_scan_driver.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared widths, types and helpers for the BCD scan display.
// Holds the conversion FSM state type and the leading-zero test.
package display_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int BIN_W      = 14;
   localparam int IDX_W      = $clog2(NUM_DIGITS);

   localparam logic [BIN_W-1:0] MAX_VAL = 14'd9999;

   typedef logic [3:0] bcd_digit_t;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      COMMIT
   } conv_state_t;

   // 1 when position p sits above the most significant nonzero digit.
   // Position 0 (ones) never reports as a leading zero.
   function automatic logic lz_blank(
      input bcd_digit_t [NUM_DIGITS-1:0] d,
      input logic [IDX_W-1:0]            p
   );
      logic z;
      logic r;
      z = 1'b1;
      r = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         if (d[i] != 4'd0) z = 1'b0;
         if (p == IDX_W'(i)) r = z;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2bcd_dd.sv
// bin2bcd_dd: double-dabble shift register, one iteration per step.
// After BIN_W steps the BCD result sits in the upper nibbles.
module bin2bcd_dd
   import display_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    step,
   input  logic [BIN_W-1:0]        bin,
   output logic [NUM_DIGITS*4-1:0] bcd
);

   localparam int SW = NUM_DIGITS * 4 + BIN_W;

   logic [SW-1:0] sr;
   logic [SW-1:0] adj;

   // add 3 to every BCD nibble that is 5 or more before the shift
   always_comb begin
      adj = sr;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sr[BIN_W + 4*i +: 4] >= 4'd5)
            adj[BIN_W + 4*i +: 4] = sr[BIN_W + 4*i +: 4] + 4'd3;
      end
   end

   // load the binary value, then shift one adjusted bit per step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sr <= '0;
      else if (start)
         sr <= SW'(bin);
      else if (step)
         sr <= {adj[SW-2:0], 1'b0};
   end

   assign bcd = sr[SW-1 -: NUM_DIGITS*4];

endmodule

// File: rtl/bcd_scan_driver.sv
// bcd_scan_driver: captures a binary value, converts it to BCD and
// scans four digits. Define LEADING_ZERO_BLANK_EN for zero blanking.
module bcd_scan_driver
   import display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [BIN_W-1:0]      bin_in,
   input  logic                  load,
   input  logic                  disp_en,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output bcd_digit_t            digit,
   output logic                  blank,
   output logic [NUM_DIGITS-1:0] an_n
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);
   localparam logic [3:0] ITER_LAST = 4'(BIN_W - 1);

   conv_state_t state;
   conv_state_t state_nxt;
   logic cap;
   logic step;
   logic commit;
   logic [3:0] iter;
   logic [BIN_W-1:0] bin_c;
   logic [NUM_DIGITS*4-1:0] bcd;
   bcd_digit_t [NUM_DIGITS-1:0] disp;
   bcd_digit_t [NUM_DIGITS-1:0] disp_nxt;
   logic valid;
   logic [PW-1:0] pre;
   logic wrap;
   logic [IDX_W-1:0] idx;
   logic [IDX_W-1:0] idx_nxt;

   assign bin_c = (bin_in > MAX_VAL) ? MAX_VAL : bin_in;
   assign busy  = (state != IDLE);

   bin2bcd_dd u_dd (
      .clk   (clk),
      .rst_n (rst_n),
      .start (cap),
      .step  (step),
      .bin   (bin_c),
      .bcd   (bcd)
   );

   // conversion state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next state and datapath strobes; loads outside IDLE are dropped
   always_comb begin
      state_nxt = state;
      cap       = 1'b0;
      step      = 1'b0;
      commit    = 1'b0;
      unique case (state)
         IDLE: begin
            if (load) begin
               cap       = 1'b1;
               state_nxt = CONV;
            end
         end
         CONV: begin
            step = 1'b1;
            if (iter == ITER_LAST) state_nxt = COMMIT;
         end
         COMMIT: begin
            commit    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // display register only changes on commit, never mid-conversion
   always_comb begin
      disp_nxt = disp;
      if (commit) disp_nxt = bcd;
   end

   // iteration count, overflow flag, commit and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iter  <= 4'd0;
         ovf   <= 1'b0;
         valid <= 1'b0;
         done  <= 1'b0;
         disp  <= '0;
      end else begin
         done <= commit;
         disp <= disp_nxt;
         if (cap) begin
            iter <= 4'd0;
            ovf  <= (bin_in > MAX_VAL);
         end else if (step) begin
            iter <= iter + 4'd1;
         end
         if (commit) valid <= 1'b1;
      end
   end

   assign wrap    = (pre == PMAX);
   assign idx_nxt = wrap ? idx + IDX_W'(1) : idx;

   // free-running prescaler and digit scan; an_n and digit move together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre   <= '0;
         idx   <= '0;
         an_n  <= 4'b1110;
         digit <= 4'd0;
      end else begin
         pre   <= wrap ? '0 : pre + PW'(1);
         idx   <= idx_nxt;
         an_n  <= ~(NUM_DIGITS'(1) << idx_nxt);
         digit <= disp_nxt[idx_nxt];
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   assign blank = ~disp_en | ~valid | lz_blank(disp, idx);
`else
   assign blank = ~disp_en | ~valid;
`endif

endmodule

// File: tb/tb_bcd_scan_driver.sv
// tb_bcd_scan_driver: directed checks of load/convert/commit timing,
// overflow clamp, busy load drop, reset abort, blanking and scan order.
module tb_bcd_scan_driver;

`ifdef LEADING_ZERO_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] bin_in;
   logic        load;
   logic        disp_en;
   logic        busy;
   logic        done;
   logic        ovf;
   logic [3:0]  digit;
   logic        blank;
   logic [3:0]  an_n;

   int n_chk  = 0;
   int n_fail = 0;

   bcd_scan_driver #(.REFRESH_DIV(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bin_in  (bin_in),
      .load    (load),
      .disp_en (disp_en),
      .busy    (busy),
      .done    (done),
      .ovf     (ovf),
      .digit   (digit),
      .blank   (blank),
      .an_n    (an_n)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // capture edge is cycle 1; lat = cycle on which done is first seen
   task automatic do_load(input logic [13:0] v, output int lat,
                          output int pulses);
      bin_in = v;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      lat    = -1;
      pulses = 0;
      for (int c = 2; c <= 24; c++) begin
         tick();
         if (done === 1'b1) begin
            pulses++;
            if (lat < 0) lat = c;
         end
      end
   endtask

   task automatic check_scan(input string nm, input logic [15:0] ed,
                             input logic [3:0] eb);
      int pos;
      int last;
      logic [3:0] seen;
      last = -1;
      seen = 4'd0;
      for (int c = 0; c < 20; c++) begin
         tick();
         case (an_n)
            4'b1110: pos = 0;
            4'b1101: pos = 1;
            4'b1011: pos = 2;
            4'b0111: pos = 3;
            default: pos = -1;
         endcase
         n_chk++;
         if (pos < 0) begin
            n_fail++;
            $display("FAIL %s an_n: got %b required one-hot low", nm, an_n);
         end else begin
            n_chk++;
            if (digit !== ed[pos*4 +: 4]) begin
               n_fail++;
               $display("FAIL %s digit[%0d]: got %0d required %0d",
                        nm, pos, digit, ed[pos*4 +: 4]);
            end
            n_chk++;
            if (blank !== eb[pos]) begin
               n_fail++;
               $display("FAIL %s blank[%0d]: got %b required %b",
                        nm, pos, blank, eb[pos]);
            end
            if (last >= 0 && pos != last) begin
               n_chk++;
               if (pos != (last + 1) % 4) begin
                  n_fail++;
                  $display("FAIL %s scan order: got %0d after %0d",
                           nm, pos, last);
               end
            end
            seen[pos] = 1'b1;
            last = pos;
         end
      end
      n_chk++;
      if (seen !== 4'hF) begin
         n_fail++;
         $display("FAIL %s positions seen: got %b required 1111", nm, seen);
      end
   endtask

   task automatic chk_load(input string nm, input int lat, input int pulses);
      n_chk++;
      if (lat !== 16) begin
         n_fail++;
         $display("FAIL %s latency: got %0d required 16", nm, lat);
      end
      n_chk++;
      if (pulses !== 1) begin
         n_fail++;
         $display("FAIL %s done pulses: got %0d required 1", nm, pulses);
      end
   endtask

   task automatic test_reset;
      rst_n   = 1'b0;
      load    = 1'b0;
      bin_in  = 14'd0;
      disp_en = 1'b1;
      tick();
      tick();
      n_chk++;
      if ({busy, done, ovf, blank} !== 4'b0001) begin
         n_fail++;
         $display("FAIL reset flags: got busy,done,ovf,blank=%b required 0001",
                  {busy, done, ovf, blank});
      end
      n_chk++;
      if ({an_n, digit} !== 8'b1110_0000) begin
         n_fail++;
         $display("FAIL reset scan: got an_n=%b digit=%0d required 1110/0",
                  an_n, digit);
      end
      rst_n = 1'b1;
      tick();
      n_chk++;
      if (blank !== 1'b1) begin
         n_fail++;
         $display("FAIL reset blank before load: got %b required 1", blank);
      end
   endtask

   task automatic test_convert;
      int lat;
      int p;
      bin_in = 14'd1234;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL conv busy: got %b required 1", busy);
      end
      lat = -1;
      p   = 0;
      for (int c = 2; c <= 24; c++) begin
         tick();
         if (done === 1'b1) begin
            p++;
            if (lat < 0) lat = c;
         end
      end
      chk_load("conv1234", lat, p);
      n_chk++;
      if ({busy, ovf} !== 2'b00) begin
         n_fail++;
         $display("FAIL conv1234 busy,ovf: got %b required 00", {busy, ovf});
      end
      check_scan("conv1234", 16'h1234, 4'b0000);
   endtask

   task automatic test_overflow;
      int lat;
      int p;
      do_load(14'd12000, lat, p);
      chk_load("ovf12000", lat, p);
      n_chk++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf12000 ovf: got %b required 1", ovf);
      end
      check_scan("ovf12000", 16'h9999, 4'b0000);
      do_load(14'd0, lat, p);
      chk_load("zero", lat, p);
      n_chk++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL zero ovf: got %b required 0", ovf);
      end
      check_scan("zero", 16'h0000, LZ ? 4'b1110 : 4'b0000);
   endtask

   task automatic test_load_while_busy;
      int p;
      bin_in = 14'd7;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      tick();
      tick();
      bin_in = 14'd3;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      p = 0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (done === 1'b1) p++;
      end
      n_chk++;
      if (p !== 1) begin
         n_fail++;
         $display("FAIL busyload done pulses: got %0d required 1", p);
      end
      n_chk++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL busyload busy at end: got %b required 0", busy);
      end
      check_scan("busyload", 16'h0007, LZ ? 4'b1110 : 4'b0000);
   endtask

   task automatic test_lz_blank;
      int lat;
      int p;
      do_load(14'd45, lat, p);
      chk_load("lz45", lat, p);
      check_scan("lz45", 16'h0045, LZ ? 4'b1100 : 4'b0000);
   endtask

   task automatic test_reset_mid_conv;
      int lat;
      int p;
      int nb;
      bin_in = 14'd16383;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      repeat (5) tick();
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst busy before reset: got %b required 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({busy, done, ovf, blank, an_n, digit} !== 12'b0001_1110_0000) begin
         n_fail++;
         $display("FAIL midrst outputs: got %b required 000111100000",
                  {busy, done, ovf, blank, an_n, digit});
      end
      tick();
      rst_n = 1'b1;
      p  = 0;
      nb = 0;
      for (int c = 0; c < 24; c++) begin
         tick();
         if (done === 1'b1) p++;
         if (blank !== 1'b1) nb++;
      end
      n_chk++;
      if (p !== 0) begin
         n_fail++;
         $display("FAIL midrst stray done: got %0d required 0", p);
      end
      n_chk++;
      if (nb !== 0) begin
         n_fail++;
         $display("FAIL midrst unblanked cycles: got %0d required 0", nb);
      end
      do_load(14'd9999, lat, p);
      chk_load("midrst9999", lat, p);
      n_chk++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst9999 ovf: got %b required 0", ovf);
      end
      check_scan("midrst9999", 16'h9999, 4'b0000);
   endtask

   task automatic test_disp_en;
      int lat;
      int p;
      int nb;
      disp_en = 1'b0;
      bin_in  = 14'd500;
      load    = 1'b1;
      tick();
      load    = 1'b0;
      lat = -1;
      p   = 0;
      nb  = 0;
      for (int c = 2; c <= 30; c++) begin
         tick();
         if (blank !== 1'b1) nb++;
         if (done === 1'b1) begin
            p++;
            if (lat < 0) lat = c;
         end
      end
      chk_load("dispen500", lat, p);
      n_chk++;
      if (nb !== 0) begin
         n_fail++;
         $display("FAIL dispen500 unblanked cycles: got %0d required 0", nb);
      end
      disp_en = 1'b1;
      check_scan("dispen500", 16'h0500, LZ ? 4'b1000 : 4'b0000);
   endtask

   initial begin
      test_reset();
      test_convert();
      test_overflow();
      test_load_while_busy();
      test_lz_blank();
      test_reset_mid_conv();
      test_disp_en();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
